ssm_modexp_seq: RTL

- Square-and-multiply modular exponentiation sequencer. Computes result = base^exp mod m.
- Sits directly upstream of the ssm modular multiplier. It issues every multiplication through a start/ready handshake and consumes each product p.
- The multiplier is external; this block holds only the sequencing state and the operand and accumulator registers.
- Left-to-right binary method with leading-zero skip.

---
 rtl/ssm_modexp_seq_if.sv | 13 +
 rtl/ssm_modexp_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ssm_modexp_seq_if.sv
// Multiplier handshake bus between the modexp sequencer (master) and the
// external ssm modular multiplier (slave).
interface ssm_modexp_seq_if #(parameter int N = 128);
  logic         mul_start;
  logic [N-1:0] mul_x;
  logic [N-1:0] mul_y;
  logic [N-1:0] mul_m;
  logic         mul_ready;
  logic [N-1:0] mul_p;

  modport master (output mul_start, mul_x, mul_y, mul_m, input mul_ready, mul_p);
  modport slave  (input mul_start, mul_x, mul_y, mul_m, output mul_ready, mul_p);
endinterface

// File: rtl/ssm_modexp_seq.sv
// Left-to-right square-and-multiply sequencer: result = base^exp mod m via an external multiplier.
// Define SSM_MODEXP_OPCNT_EN to add the op_count port (multiplications issued per operation).
//
// state   | meaning
// IDLE    | waiting for start, operands not yet latched
// SCAN    | skipping leading zeros of the exponent
// NEXT    | finish, or issue the square for the next exponent bit
// SQ_ARM  | square just issued; ready from the previous product is ignored
// SQ_WAIT | waiting for the square product
// ML_ARM  | multiply-by-base just issued; ready ignored
// ML_WAIT | waiting for the multiply product
// FIN     | result valid, done pulse
module ssm_modexp_seq #(
  parameter int N = 128
`ifdef SSM_MODEXP_OPCNT_EN
  , parameter int CW = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  base,
  input  logic [N-1:0]  exp,
  input  logic [N-1:0]  m,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
`ifdef SSM_MODEXP_OPCNT_EN
  output logic [CW-1:0] op_count,
`endif
  ssm_modexp_seq_if.master mul
);

  localparam int BLW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, NEXT, SQ_ARM, SQ_WAIT, ML_ARM, ML_WAIT, FIN
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   e_q, e_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   res_d, x_d, y_d, m_d;
  logic [BLW-1:0] bl_q, bl_d;
  logic           start_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      b_q           <= '0;
      e_q           <= '0;
      acc_q         <= '0;
      bl_q          <= '0;
      result        <= '0;
      mul.mul_start <= 1'b0;
      mul.mul_x     <= '0;
      mul.mul_y     <= '0;
      mul.mul_m     <= '0;
    end else begin
      state_q       <= state_d;
      b_q           <= b_d;
      e_q           <= e_d;
      acc_q         <= acc_d;
      bl_q          <= bl_d;
      result        <= res_d;
      mul.mul_start <= start_d;
      mul.mul_x     <= x_d;
      mul.mul_y     <= y_d;
      mul.mul_m     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    e_d     = e_q;
    acc_d   = acc_q;
    bl_d    = bl_q;
    res_d   = result;
    x_d     = mul.mul_x;
    y_d     = mul.mul_y;
    m_d     = mul.mul_m;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = base;
          e_d     = exp;
          m_d     = m;
          bl_d    = BLW'(N - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (e_q == '0) begin
          // x^0 mod 1 is 0, otherwise 1
          acc_d   = (mul.mul_m == N'(1)) ? '0 : N'(1);
          res_d   = acc_d;
          state_d = FIN;
        end else if (e_q[N-1]) begin
          acc_d   = b_q;
          e_d     = e_q << 1;
          state_d = NEXT;
        end else begin
          e_d  = e_q << 1;
          bl_d = bl_q - BLW'(1);
        end
      end
      NEXT: begin
        if (bl_q == '0) begin
          res_d   = acc_q;
          state_d = FIN;
        end else begin
          x_d     = acc_q;
          y_d     = acc_q;
          start_d = 1'b1;
          state_d = SQ_ARM;
        end
      end
      SQ_ARM: state_d = SQ_WAIT;
      SQ_WAIT: begin
        if (mul.mul_ready) begin
          acc_d = mul.mul_p;
          if (e_q[N-1]) begin
            x_d     = mul.mul_p;
            y_d     = b_q;
            start_d = 1'b1;
            state_d = ML_ARM;
          end else begin
            e_d     = e_q << 1;
            bl_d    = bl_q - BLW'(1);
            state_d = NEXT;
          end
        end
      end
      ML_ARM: state_d = ML_WAIT;
      ML_WAIT: begin
        if (mul.mul_ready) begin
          acc_d   = mul.mul_p;
          e_d     = e_q << 1;
          bl_d    = bl_q - BLW'(1);
          state_d = NEXT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) && (state_q != FIN);
  assign done = (state_q == FIN);

`ifdef SSM_MODEXP_OPCNT_EN
  logic [CW-1:0] opc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q <= '0;
    end else if (state_q == IDLE && start) begin
      opc_q <= '0;
    end else if (start_d && opc_q != '1) begin
      opc_q <= opc_q + CW'(1);
    end
  end

  assign op_count = opc_q;
`endif

endmodule
